// File: rtl/cover_toggle_sched.sv
// Toggle-cover report scheduler: merges NUM_REQ hit vectors into one stream of global cover indices.
// Latency: a hit sampled on edge k shows up on out_valid after edge k+1; one index per cycle after that.
// Backpressure: out_valid/out_index hold while out_ready=0; pending hits keep accumulating meanwhile.
// Optional build macro COVER_SCHED_DEDUP_EN: report each cover point at most once between resets.
module cover_toggle_sched #(
    parameter int NUM_REQ    = 4,
    parameter int WIDTH      = 44,
    parameter int BASE_INDEX = 0,
    parameter int IDX_W      = 32
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic [NUM_REQ*WIDTH-1:0] hit,
    input  logic                     flush,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [IDX_W-1:0]         out_index,
    output logic                     busy,
    output logic [31:0]              emit_count
);

    localparam int TOTAL = NUM_REQ * WIDTH;
    localparam int PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int BIT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    logic [TOTAL-1:0] pending;
    logic [TOTAL-1:0] cleared;
    logic [TOTAL-1:0] hit_masked;
    logic [PTR_W-1:0] rr_ptr;

    logic [NUM_REQ-1:0] req_any;
    logic [BIT_W-1:0]   low_bit [NUM_REQ];
    logic               sel_found;
    logic [PTR_W-1:0]   sel_r;
    int                 sel_flat;
    logic               free_slot;
    logic               load;

`ifdef COVER_SCHED_DEDUP_EN
    logic [TOTAL-1:0] covered;
`endif

    // Per-requester summary: any pending bit, and the lowest pending bit position.
    always_comb begin
        for (int r = 0; r < NUM_REQ; r++) begin
            req_any[r] = |pending[r*WIDTH +: WIDTH];
            low_bit[r] = '0;
            for (int b = WIDTH - 1; b >= 0; b--) begin
                if (pending[r*WIDTH + b]) begin
                    low_bit[r] = BIT_W'(b);
                end
            end
        end
    end

    // Round-robin requester pick: first pass from rr_ptr upward, second pass wraps to 0.
    always_comb begin
        sel_found = 1'b0;
        sel_r     = '0;
        for (int r = 0; r < NUM_REQ; r++) begin
            if (!sel_found && req_any[r] && (r >= int'(rr_ptr))) begin
                sel_found = 1'b1;
                sel_r     = PTR_W'(r);
            end
        end
        for (int r = 0; r < NUM_REQ; r++) begin
            if (!sel_found && req_any[r]) begin
                sel_found = 1'b1;
                sel_r     = PTR_W'(r);
            end
        end
    end

    // Load decision and the one-hot bit consumed by this load; flush blocks loading.
    always_comb begin
        free_slot = !out_valid || out_ready;
        load      = free_slot && sel_found && !flush;
        sel_flat  = int'(sel_r) * WIDTH + int'(low_bit[sel_r]);
        cleared   = '0;
        if (load) begin
            cleared[sel_flat] = 1'b1;
        end
    end

    // Incoming hits; with dedup, already-reported points (including the one loading now) are masked.
    always_comb begin
`ifdef COVER_SCHED_DEDUP_EN
        hit_masked = hit & ~(covered | cleared);
`else
        hit_masked = hit;
`endif
    end

    // Busy while anything is queued or an index waits in the output register.
    always_comb begin
        busy = (|pending) || out_valid;
    end

    // Pending bitmap, output register, round-robin pointer and transfer counter.
    always_ff @(posedge clock) begin
        if (!reset) begin
            pending    <= '0;
            out_valid  <= 1'b0;
            out_index  <= '0;
            rr_ptr     <= '0;
            emit_count <= '0;
`ifdef COVER_SCHED_DEDUP_EN
            covered    <= '0;
`endif
        end else begin
            if (out_valid && out_ready && (emit_count != 32'hFFFF_FFFF)) begin
                emit_count <= emit_count + 32'd1;
            end

            if (flush) begin
                pending <= '0;
            end else begin
                pending <= (pending & ~cleared) | hit_masked;
            end

            if (load) begin
                out_valid <= 1'b1;
                out_index <= IDX_W'(BASE_INDEX) + IDX_W'(sel_flat);
                if (int'(sel_r) == NUM_REQ - 1) begin
                    rr_ptr <= '0;
                end else begin
                    rr_ptr <= sel_r + PTR_W'(1);
                end
`ifdef COVER_SCHED_DEDUP_EN
                covered <= covered | cleared;
`endif
            end else if (free_slot) begin
                out_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_cover_toggle_sched.sv
// Directed bench for cover_toggle_sched with BASE_INDEX=100, other parameters default.
// Inputs change 1 time unit after each rising edge; outputs are checked at the same point.
// Expected values are hand-derived from the scheduling rules (round-robin, lowest bit first).
module tb_cover_toggle_sched;

    localparam int NUM_REQ = 4;
    localparam int WIDTH   = 44;
    localparam int IDX_W   = 32;

    logic                     clock;
    logic                     reset;
    logic [NUM_REQ*WIDTH-1:0] hit;
    logic                     flush;
    logic                     out_valid;
    logic                     out_ready;
    logic [IDX_W-1:0]         out_index;
    logic                     busy;
    logic [31:0]              emit_count;

    int checks;
    int failures;
    int reports;
    int exp_reports;

    cover_toggle_sched #(
        .NUM_REQ   (NUM_REQ),
        .WIDTH     (WIDTH),
        .BASE_INDEX(100),
        .IDX_W     (IDX_W)
    ) dut (
        .clock     (clock),
        .reset     (reset),
        .hit       (hit),
        .flush     (flush),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_index (out_index),
        .busy      (busy),
        .emit_count(emit_count)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic do_reset();
        reset = 1'b0;
        tick();
        tick();
        reset = 1'b1;
    endtask

    initial begin
        checks    = 0;
        failures  = 0;
        reset     = 1'b0;
        hit       = '0;
        flush     = 1'b0;
        out_ready = 1'b1;

        // Reset state
        do_reset();
        check("rst_valid", 64'(out_valid), 64'd0);
        check("rst_index", 64'(out_index), 64'd0);
        check("rst_emit",  64'(emit_count), 64'd0);
        check("rst_busy",  64'(busy), 64'd0);

        // Single hit on bit 5: two-edge latency, single beat
        hit[5] = 1'b1;
        tick();
        hit = '0;
        check("t1_valid_e1", 64'(out_valid), 64'd0);
        check("t1_busy_e1",  64'(busy), 64'd1);
        tick();
        check("t1_valid_e2", 64'(out_valid), 64'd1);
        check("t1_index_e2", 64'(out_index), 64'd105);
        check("t1_emit_e2",  64'(emit_count), 64'd0);
        tick();
        check("t1_valid_e3", 64'(out_valid), 64'd0);
        check("t1_emit_e3",  64'(emit_count), 64'd1);
        check("t1_busy_e3",  64'(busy), 64'd0);

        // Three requesters hit in one cycle: back-to-back 100, 144, 190
        do_reset();
        hit[0]  = 1'b1;
        hit[44] = 1'b1;
        hit[90] = 1'b1;
        tick();
        hit = '0;
        tick();
        check("t2_idx0", 64'(out_index), 64'd100);
        check("t2_vld0", 64'(out_valid), 64'd1);
        tick();
        check("t2_idx1", 64'(out_index), 64'd144);
        check("t2_vld1", 64'(out_valid), 64'd1);
        tick();
        check("t2_idx2", 64'(out_index), 64'd190);
        check("t2_vld2", 64'(out_valid), 64'd1);
        tick();
        check("t2_vld_end",  64'(out_valid), 64'd0);
        check("t2_busy_end", 64'(busy), 64'd0);
        check("t2_emit_end", 64'(emit_count), 64'd3);

        // Backpressure: output held for 5 cycles, then drains 105, 106
        do_reset();
        out_ready = 1'b0;
        hit[5] = 1'b1;
        hit[6] = 1'b1;
        tick();
        hit = '0;
        tick();
        for (int i = 0; i < 5; i++) begin
            check("t3_hold_vld",  64'(out_valid), 64'd1);
            check("t3_hold_idx",  64'(out_index), 64'd105);
            check("t3_hold_emit", 64'(emit_count), 64'd0);
            tick();
        end
        out_ready = 1'b1;
        tick();
        check("t3_next_idx",  64'(out_index), 64'd106);
        check("t3_next_emit", 64'(emit_count), 64'd1);
        tick();
        check("t3_end_vld",  64'(out_valid), 64'd0);
        check("t3_end_emit", 64'(emit_count), 64'd2);

        // Round-robin across requesters: 100, 144, 101
        do_reset();
        hit[0]  = 1'b1;
        hit[1]  = 1'b1;
        hit[44] = 1'b1;
        tick();
        hit = '0;
        tick();
        check("t4_idx0", 64'(out_index), 64'd100);
        tick();
        check("t4_idx1", 64'(out_index), 64'd144);
        tick();
        check("t4_idx2", 64'(out_index), 64'd101);
        check("t4_vld2", 64'(out_valid), 64'd1);
        tick();
        check("t4_vld_end", 64'(out_valid), 64'd0);

        // Flush drops pending but leaves the held output intact
        do_reset();
        out_ready = 1'b0;
        hit[7] = 1'b1;
        hit[8] = 1'b1;
        tick();
        hit = '0;
        tick();
        check("t5_idx", 64'(out_index), 64'd107);
        flush = 1'b1;
        hit[9] = 1'b1;
        tick();
        flush = 1'b0;
        hit = '0;
        check("t5_flush_vld", 64'(out_valid), 64'd1);
        check("t5_flush_idx", 64'(out_index), 64'd107);
        out_ready = 1'b1;
        tick();
        check("t5_after_vld",  64'(out_valid), 64'd0);
        check("t5_after_busy", 64'(busy), 64'd0);

        // Same point hit three times, each after its previous emission
        do_reset();
        reports = 0;
        for (int n = 0; n < 3; n++) begin
            hit[3] = 1'b1;
            tick();
            hit = '0;
            for (int c = 0; c < 3; c++) begin
                if (out_valid) begin
                    reports++;
                    check("t6_idx", 64'(out_index), 64'd103);
                end
                tick();
            end
        end
`ifdef COVER_SCHED_DEDUP_EN
        exp_reports = 1;
`else
        exp_reports = 3;
`endif
        check("t6_reports", 64'(reports), 64'(exp_reports));
        check("t6_emit",    64'(emit_count), 64'(exp_reports));

        // Reset mid-handshake discards the held index and everything pending
        do_reset();
        out_ready = 1'b0;
        hit[5]  = 1'b1;
        hit[10] = 1'b1;
        tick();
        hit = '0;
        tick();
        check("t7_pre_vld", 64'(out_valid), 64'd1);
        reset = 1'b0;
        tick();
        check("t7_rst_vld",  64'(out_valid), 64'd0);
        check("t7_rst_idx",  64'(out_index), 64'd0);
        check("t7_rst_emit", 64'(emit_count), 64'd0);
        check("t7_rst_busy", 64'(busy), 64'd0);
        reset = 1'b1;
        out_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            check("t7_post_vld",  64'(out_valid), 64'd0);
            check("t7_post_busy", 64'(busy), 64'd0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
